// File: rtl/fft_iter_ctrl_if.sv
// Control/address bundle between the iterative FFT sequencer and the
// memory / butterfly / twiddle datapath it drives.
interface fft_iter_ctrl_if #(
   parameter int AWL = 5
);
   logic           START;
   logic           BUSY;
   logic           DONE;
   logic [AWL-1:0] STAGE;
   logic           RD_EN;
   logic [AWL-1:0] RD_ADDR_A;
   logic [AWL-1:0] RD_ADDR_B;
   logic           WR_EN;
   logic [AWL-1:0] WR_ADDR_A;
   logic [AWL-1:0] WR_ADDR_B;
   logic           TW_EN;
   logic           TW_LAY_EN;

   // Sequencer side: takes START, issues every strobe and address.
   modport master (
      input  START,
      output BUSY, DONE, STAGE,
      output RD_EN, RD_ADDR_A, RD_ADDR_B,
      output WR_EN, WR_ADDR_A, WR_ADDR_B,
      output TW_EN, TW_LAY_EN
   );

   // Datapath / host side.
   modport slave (
      output START,
      input  BUSY, DONE, STAGE,
      input  RD_EN, RD_ADDR_A, RD_ADDR_B,
      input  WR_EN, WR_ADDR_A, WR_ADDR_B,
      input  TW_EN, TW_LAY_EN
   );
endinterface

// File: rtl/fft_iter_ctrl.sv
// Sequencer for an in-place radix-2 DIT iterative FFT (N = 2**AWL points).
// Each stage issues N/2 butterfly reads, then drains LAT cycles so the last
// write-back of a stage lands before the first read of the next stage.
// Write-back addresses are the read addresses delayed by LAT cycles.
module fft_iter_ctrl #(
   parameter int AWL = 5,
   parameter int LAT = 3
) (
   input  logic            CLK,
   input  logic            RST,
   fft_iter_ctrl_if.master bus
);

   localparam int H  = 2 ** (AWL - 1);
   localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [AWL-1:0] J_LAST = AWL'(H - 1);
   localparam logic [AWL-1:0] S_LAST = AWL'(AWL - 1);
   localparam logic [DW-1:0]  D_LAST = DW'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         r_state;
   logic [AWL-1:0] r_j;
   logic [AWL-1:0] r_stage;
   logic [DW-1:0]  r_dcnt;
   logic           r_busy;
   logic           r_done;
   logic           r_rd_en;
   logic           r_lay_en;
   logic [AWL-1:0] r_rd_a;
   logic [AWL-1:0] r_rd_b;

   logic [LAT-1:0]     r_dv;
   logic [LAT-1:0]     w_dv_next;
   logic [LAT*AWL-1:0] r_da;
   logic [LAT*AWL-1:0] r_db;
   logic [LAT*AWL-1:0] w_da_next;
   logic [LAT*AWL-1:0] w_db_next;

   // Top operand: butterfly index j with a zero inserted at bit position s,
   // i.e. g*2**(s+1) + k with k = j mod 2**s, g = j >> s.
   function automatic logic [AWL-1:0] f_addr_a(input logic [AWL-1:0] s,
                                                input logic [AWL-1:0] j);
      logic [AWL-1:0] m;
      m = (AWL'(1) << s) - AWL'(1);
      return ((j & ~m) << 1) | (j & m);
   endfunction

   // Bottom operand: same address with bit s set (no carry possible).
   function automatic logic [AWL-1:0] f_addr_b(input logic [AWL-1:0] s,
                                                input logic [AWL-1:0] j);
      return f_addr_a(s, j) | (AWL'(1) << s);
   endfunction

   // Frame FSM; every output register is loaded with the value for the
   // state being entered, so no output depends combinationally on START.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_j      <= '0;
         r_stage  <= '0;
         r_dcnt   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rd_en  <= 1'b0;
         r_lay_en <= 1'b0;
         r_rd_a   <= '0;
         r_rd_b   <= '0;
      end else begin
         r_done   <= 1'b0;
         r_rd_en  <= 1'b0;
         r_lay_en <= 1'b0;
         r_rd_a   <= '0;
         r_rd_b   <= '0;
         case (r_state)
            S_IDLE: begin
               if (bus.START) begin
                  r_state <= S_RUN;
                  r_j     <= '0;
                  r_stage <= '0;
                  r_busy  <= 1'b1;
                  r_rd_en <= 1'b1;
                  r_rd_a  <= f_addr_a(AWL'(0), AWL'(0));
                  r_rd_b  <= f_addr_b(AWL'(0), AWL'(0));
               end
            end
            S_RUN: begin
               if (r_j == J_LAST) begin
                  r_state  <= S_DRAIN;
                  r_dcnt   <= '0;
                  r_lay_en <= 1'b1;
               end else begin
                  r_j     <= r_j + AWL'(1);
                  r_rd_en <= 1'b1;
                  r_rd_a  <= f_addr_a(r_stage, r_j + AWL'(1));
                  r_rd_b  <= f_addr_b(r_stage, r_j + AWL'(1));
               end
            end
            S_DRAIN: begin
               if (r_dcnt == D_LAST) begin
                  if (r_stage == S_LAST) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_stage <= r_stage + AWL'(1);
                     r_j     <= '0;
                     r_rd_en <= 1'b1;
                     r_rd_a  <= f_addr_a(r_stage + AWL'(1), AWL'(0));
                     r_rd_b  <= f_addr_b(r_stage + AWL'(1), AWL'(0));
                  end
               end else begin
                  r_dcnt <= r_dcnt + DW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_stage <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Next contents of the write-back delay line; a single-entry line is
   // just the read strobe/addresses themselves.
   generate
      if (LAT == 1) begin : g_lat1
         assign w_dv_next = r_rd_en;
         assign w_da_next = r_rd_a;
         assign w_db_next = r_rd_b;
      end else begin : g_latn
         assign w_dv_next = {r_dv[LAT-2:0], r_rd_en};
         assign w_da_next = {r_da[(LAT-1)*AWL-1:0], r_rd_a};
         assign w_db_next = {r_db[(LAT-1)*AWL-1:0], r_rd_b};
      end
   endgenerate

   // LAT-deep {valid, A, B} shift register; reset drops pending writes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_dv <= '0;
         r_da <= '0;
         r_db <= '0;
      end else begin
         r_dv <= w_dv_next;
         r_da <= w_da_next;
         r_db <= w_db_next;
      end
   end

   assign bus.BUSY      = r_busy;
   assign bus.DONE      = r_done;
   assign bus.STAGE     = r_stage;
   assign bus.RD_EN     = r_rd_en;
   assign bus.RD_ADDR_A = r_rd_a;
   assign bus.RD_ADDR_B = r_rd_b;
   assign bus.TW_EN     = r_rd_en;
   assign bus.TW_LAY_EN = r_lay_en;
   assign bus.WR_EN     = r_dv[LAT-1];
   assign bus.WR_ADDR_A = r_da[LAT*AWL-1 -: AWL];
   assign bus.WR_ADDR_B = r_db[LAT*AWL-1 -: AWL];

endmodule
